sprite_rom_responder: RTL and testbench
=======================================

SPRITE_ROM_RESPONDER -- requirements
Module: sprite_rom_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 18, meaning the request address width in bits.
REQ-002 SHALL have parameter ROM_WORDS, default 131072, meaning the number of valid 8-bit sprite pixel words.
REQ-003 SHALL have parameter LAT, default 2, meaning the ROM read latency in cycles (1..4).
REQ-004 SHALL have parameter DEPTH, default 4, meaning the maximum outstanding requests (power of 2, >= LAT).
REQ-005 SHALL have port SYS_CLK, in, 1, the single system clock; all logic is on its rising edge.
REQ-006 SHALL have port RESET_N, in, 1, the reset: synchronous, active-low.
REQ-007 SHALL have port req_valid, in, 1, meaning the sprite fetch master presents a read request.
REQ-008 SHALL have port req_addr, in, ADDR_W, meaning the pixel word address.
REQ-009 SHALL have port req_ready, out, 1, meaning the request is accepted this cycle when req_valid is also high.
REQ-010 SHALL have port rom_addr, out, ADDR_W, the address to the synchronous ROM.
REQ-011 SHALL have port rom_rden, out, 1, the ROM read strobe.
REQ-012 SHALL have port rom_q, in, 8, the ROM data, valid LAT cycles after rom_rden.
REQ-013 SHALL have port rsp_valid, out, 1, meaning a response word is presented.
REQ-014 SHALL have port rsp_data, out, 8, the pixel data of the head response.
REQ-015 SHALL have port rsp_err, out, 1, meaning the head response was for an out-of-range address.
REQ-016 SHALL have port rsp_ready, in, 1, meaning the consumer takes the head response this cycle.
REQ-017 SHALL have port outstanding, out, $clog2(DEPTH)+1, the in-flight count plus the queued-response count.

Function
REQ-018 SHALL accept a request on a cycle where req_valid && req_ready; no other cycle is an acceptance.
REQ-019 SHALL drive req_ready = (outstanding < DEPTH), using registered state only, with no combinational path from rsp_ready or req_valid.
REQ-020 SHALL, on acceptance with req_addr < ROM_WORDS, assert rom_rden with rom_addr = req_addr in the same cycle.
REQ-021 SHALL, on acceptance with req_addr >= ROM_WORDS, keep rom_rden low and tag the slot as error.
REQ-022 SHALL hold rom_rden low and rom_addr = 0 in all cycles without acceptance.
REQ-023 SHALL track every accepted request in a LAT-stage valid/error shift pipeline.
REQ-024 SHALL, when a tag exits the pipeline, push {rom_q, err=0} into the response FIFO for a normal slot, or {8'h00, err=1} for an error slot.
REQ-025 SHALL return responses strictly in acceptance order.
REQ-026 SHALL give rsp_valid = FIFO not empty, with rsp_data and rsp_err taken from the FIFO head (show-ahead).
REQ-027 SHALL hold rsp_data and rsp_err stable while rsp_valid && !rsp_ready.
REQ-028 SHALL pop the FIFO on rsp_valid && rsp_ready.
REQ-029 SHALL give a minimum latency from acceptance to rsp_valid of LAT+1 cycles (rsp_valid at cycle T+LAT+1 for acceptance at T).
REQ-030 SHALL update outstanding next cycle as +1 on acceptance, -1 on pop, and unchanged when both or neither occur.
REQ-031 SHALL never let the response FIFO overflow (guaranteed by REQ-019); FIFO pointers wrap modulo DEPTH.
REQ-032 SHALL, with rsp_ready held high and req_valid held high, sustain 1 request and 1 response per cycle after the initial latency.
REQ-033 SHALL, with rsp_ready held low, accept exactly DEPTH requests, then hold req_ready low until the first pop, and raise req_ready on the cycle after that pop.

Reset
REQ-034 SHALL, with RESET_N low at a clock edge, clear the pipeline, the FIFO pointers and outstanding.
REQ-035 SHALL drive these outputs during and after reset: req_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, rom_rden=0, rom_addr=0, outstanding=0.
REQ-036 SHALL, on reset mid-operation, discard in-flight and queued responses without emitting them; any rom_q arriving afterward SHALL be ignored.
REQ-037 SHALL ignore req_valid while RESET_N is low.

Verification
REQ-038 SHALL cover a single read: addr 0x00010 with ROM[0x10]=8'hA5 and rsp_ready=1 -> rsp_valid exactly at T+3 (LAT=2), rsp_data=A5, rsp_err=0, outstanding back to 0.
REQ-039 SHALL cover streaming: addrs 0..7 back-to-back with rsp_ready=1 -> 8 responses in order on consecutive cycles and req_ready never low.
REQ-040 SHALL cover backpressure: rsp_ready=0 with 6 requests offered -> exactly 4 accepted, outstanding=4, req_ready=0; then one pop -> req_ready=1 next cycle and the 5th request accepted.
REQ-041 SHALL cover out of range: addr 0x20000 (=ROM_WORDS) between two valid reads -> rom_rden low on that cycle and responses {d0,0},{00,1},{d2,0} in order.
REQ-042 SHALL cover reset mid-flight: 3 accepted with 2 responses queued, RESET_N low 1 cycle -> next cycle rsp_valid=0, outstanding=0, req_ready=1, and no stale response ever appears.
REQ-043 SHALL cover simultaneous accept and pop with outstanding=4 -> no acceptance (req_ready=0); with outstanding=3 both occur and outstanding stays 3.

Source files
------------

// File: rtl/sprite_rom_responder.sv
// rtl/sprite_rom_responder.sv - in-order sprite ROM read responder with latency tracking and response FIFO
module sprite_rom_responder #(
  parameter int ADDR_W    = 18,
  parameter int ROM_WORDS = 131072,
  parameter int LAT       = 2,
  parameter int DEPTH     = 4
) (
  input  logic                       SYS_CLK,
  input  logic                       RESET_N,
  input  logic                       req_valid,
  input  logic [ADDR_W-1:0]          req_addr,
  output logic                       req_ready,
  output logic [ADDR_W-1:0]          rom_addr,
  output logic                       rom_rden,
  input  logic [7:0]                 rom_q,
  output logic                       rsp_valid,
  output logic [7:0]                 rsp_data,
  output logic                       rsp_err,
  input  logic                       rsp_ready,
  output logic [$clog2(DEPTH):0]     outstanding
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [LAT-1:0]   v_pipe;
  logic [LAT-1:0]   e_pipe;
  logic [8:0]       mem [DEPTH];
  logic [CNT_W-1:0] wr_ptr;
  logic [CNT_W-1:0] rd_ptr;
  logic [8:0]       head_word;
  logic [8:0]       push_word;
  logic             in_range;
  logic             accept;
  logic             push;
  logic             pop;

  // The count covers both in-flight and queued slots, so it also bounds FIFO occupancy.
  assign req_ready = (outstanding < CNT_W'(DEPTH));
  assign in_range  = ({1'b0, req_addr} < (ADDR_W + 1)'(ROM_WORDS));
  assign accept    = req_valid && req_ready && RESET_N;
  assign rom_rden  = accept && in_range;
  assign rom_addr  = rom_rden ? req_addr : '0;

  assign push      = v_pipe[LAT-1];
  assign push_word = e_pipe[LAT-1] ? 9'h001 : {rom_q, 1'b0};
  assign rsp_valid = (wr_ptr != rd_ptr);
  assign pop       = rsp_valid && rsp_ready;
  assign head_word = mem[rd_ptr[PTR_W-1:0]];
  assign rsp_data  = rsp_valid ? head_word[8:1] : 8'h00;
  assign rsp_err   = rsp_valid && head_word[0];

  always_ff @(posedge SYS_CLK) begin
    if (!RESET_N) begin
      v_pipe      <= '0;
      e_pipe      <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
    end else begin
      for (int i = LAT - 1; i > 0; i--) begin
        v_pipe[i] <= v_pipe[i-1];
        e_pipe[i] <= e_pipe[i-1];
      end
      v_pipe[0] <= accept;
      e_pipe[0] <= accept && !in_range;
      if (push) wr_ptr <= wr_ptr + CNT_W'(1);
      if (pop)  rd_ptr <= rd_ptr + CNT_W'(1);
      case ({accept, pop})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Storage needs no reset: the pointers alone decide what is visible.
  always_ff @(posedge SYS_CLK) begin
    if (RESET_N && push) mem[wr_ptr[PTR_W-1:0]] <= push_word;
  end

endmodule

// File: tb/tb_sprite_rom_responder.sv
// tb/tb_sprite_rom_responder.sv - scoreboard bench for sprite_rom_responder
module tb_sprite_rom_responder;
  localparam int ADDR_W    = 18;
  localparam int ROM_WORDS = 131072;
  localparam int LAT       = 2;
  localparam int DEPTH     = 4;
  localparam int CNT_W     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              RESET_N;
  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              req_ready;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_rden;
  logic [7:0]        rom_q;
  logic              rsp_valid;
  logic [7:0]        rsp_data;
  logic              rsp_err;
  logic              rsp_ready;
  logic [CNT_W-1:0]  outstanding;

  sprite_rom_responder #(
    .ADDR_W(ADDR_W), .ROM_WORDS(ROM_WORDS), .LAT(LAT), .DEPTH(DEPTH)
  ) dut (
    .SYS_CLK(clk), .RESET_N(RESET_N), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .rom_addr(rom_addr), .rom_rden(rom_rden), .rom_q(rom_q),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .rsp_ready(rsp_ready), .outstanding(outstanding)
  );

  always #5 clk = ~clk;

  int checks_total  = 0;
  int checks_passed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [7:0] rom_val(input logic [ADDR_W-1:0] a);
    if (a == 18'h00010) return 8'hA5;
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  // Synchronous ROM model; garbage when no read is due so misaligned capture shows up.
  logic [LAT-1:0]    rom_v = '0;
  logic [ADDR_W-1:0] rom_a [LAT];
  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) begin
      rom_v[i] <= rom_v[i-1];
      rom_a[i] <= rom_a[i-1];
    end
    rom_v[0] <= rom_rden;
    rom_a[0] <= rom_addr;
  end
  assign rom_q = rom_v[LAT-1] ? rom_val(rom_a[LAT-1]) : 8'hEE;

  logic [8:0] exp_q[$];
  int         pop_cyc[$];
  int         model_out = 0;
  int         acc_cnt   = 0;
  int         pop_cnt   = 0;
  int         err_cnt   = 0;
  int         cyc       = 0;
  logic       mon_en    = 1'b0;

  always @(negedge clk) begin : monitor
    logic acc;
    logic ok_range;
    logic popped;
    cyc++;
    if (mon_en) begin
      acc      = RESET_N && req_valid && (model_out < DEPTH);
      ok_range = (int'(req_addr) < ROM_WORDS);
      popped   = 1'b0;
      check("req_ready", req_ready, model_out < DEPTH);
      check("outstanding", outstanding, model_out);
      check("rom_rden", rom_rden, acc && ok_range);
      check("rom_addr", rom_addr, (acc && ok_range) ? req_addr : '0);
      if (exp_q.size() == 0) begin
        check("no_rsp_when_idle", rsp_valid, 1'b0);
      end else if (rsp_valid) begin
        check("rsp_word", {rsp_data, rsp_err}, exp_q[0]);
        if (rsp_ready && RESET_N) begin
          if (exp_q[0][0]) err_cnt++;
          void'(exp_q.pop_front());
          pop_cyc.push_back(cyc);
          pop_cnt++;
          popped = 1'b1;
        end
      end
      if (!RESET_N) begin
        exp_q.delete();
        model_out = 0;
      end else begin
        model_out = model_out + int'(acc) - int'(popped);
        if (acc) begin
          acc_cnt++;
          exp_q.push_back(ok_range ? {rom_val(req_addr), 1'b0} : 9'h001);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat;
    int base;
    int pbase;
    int ebase;
    logic [ADDR_W-1:0] oor_addrs [4];

    RESET_N   = 1'b0;
    req_valid = 1'b1;
    req_addr  = 18'h00010;
    rsp_ready = 1'b0;
    tick();
    mon_en = 1'b1;
    tick();
    @(negedge clk);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_data", rsp_data, 8'h00);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_rom_rden", rom_rden, 1'b0);
    check("rst_rom_addr", rom_addr, '0);
    check("rst_outstanding", outstanding, '0);
    tick();
    RESET_N   = 1'b1;
    req_valid = 1'b0;
    tick();

    // single read latency
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_addr  = 18'h00010;
    tick();
    req_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (rsp_valid && lat == 0) begin
        lat = k;
        check("single_data", {rsp_data, rsp_err}, {8'hA5, 1'b0});
      end
      tick();
    end
    check("single_latency", lat, LAT + 1);
    @(negedge clk);
    check("single_outstanding", outstanding, '0);
    tick();

    // streaming
    pop_cyc.delete();
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1;
      req_addr  = ADDR_W'(i);
      @(negedge clk);
      check("stream_ready", req_ready, 1'b1);
      tick();
    end
    req_valid = 1'b0;
    repeat (8) tick();
    check("stream_count", pop_cyc.size(), 8);
    if (pop_cyc.size() == 8) check("stream_back_to_back", pop_cyc[7] - pop_cyc[0], 7);

    // backpressure, then pop and accept interplay at the full boundary
    rsp_ready = 1'b0;
    base = acc_cnt;
    for (int i = 0; i < 6; i++) begin
      req_valid = 1'b1;
      req_addr  = ADDR_W'(32'h100 + i);
      tick();
    end
    req_valid = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    check("bp_accepted", acc_cnt - base, 4);
    check("bp_outstanding", outstanding, 3'd4);
    check("bp_ready_low", req_ready, 1'b0);
    tick();
    req_valid = 1'b1;
    req_addr  = 18'h00105;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("full_no_accept", req_ready, 1'b0);
    check("full_rsp_valid", rsp_valid, 1'b1);
    tick();
    @(negedge clk);
    check("after_pop_ready", req_ready, 1'b1);
    check("after_pop_outstanding", outstanding, 3'd3);
    tick();
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("both_outstanding", outstanding, 3'd3);
    check("bp_fifth_accepted", acc_cnt - base, 5);
    rsp_ready = 1'b1;
    repeat (12) tick();
    check("bp_drained", outstanding, '0);

    // out of range between valid reads, plus the last valid word
    oor_addrs[0] = 18'h00030;
    oor_addrs[1] = 18'h20000;
    oor_addrs[2] = 18'h00031;
    oor_addrs[3] = 18'h1FFFF;
    pbase = pop_cnt;
    ebase = err_cnt;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1;
      req_addr  = oor_addrs[i];
      @(negedge clk);
      check("oor_rden", rom_rden, int'(oor_addrs[i]) < ROM_WORDS);
      tick();
    end
    req_valid = 1'b0;
    repeat (8) tick();
    check("oor_pops", pop_cnt - pbase, 4);
    check("oor_errs", err_cnt - ebase, 1);

    // reset mid-flight
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1;
      req_addr  = ADDR_W'(32'h40 + i);
      tick();
    end
    req_valid = 1'b0;
    tick();
    RESET_N = 1'b0;
    @(negedge clk);
    check("mid_outstanding", outstanding, 3'd3);
    check("mid_rsp_valid", rsp_valid, 1'b1);
    tick();
    RESET_N = 1'b1;
    @(negedge clk);
    check("post_rst_rsp_valid", rsp_valid, 1'b0);
    check("post_rst_outstanding", outstanding, '0);
    check("post_rst_ready", req_ready, 1'b1);
    rsp_ready = 1'b1;
    repeat (10) tick();

    // recovery read
    req_valid = 1'b1;
    req_addr  = 18'h00010;
    tick();
    req_valid = 1'b0;
    repeat (6) tick();
    check("recover_outstanding", outstanding, '0);
    check("recover_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
